// File: rtl/f_adder.sv
// ----------------------------------------------------------------------------
// f_adder
//   Unsigned WIDTH-bit adder. The 2*WIDTH-bit sum is returned as two halves:
//   a holds the upper half (only bit 0, the carry out, can be set) and b
//   holds the lower half. The carry chain is a two-level carry-lookahead
//   structure: 4-bit CLA groups feed a second-level lookahead unit, so no
//   carry ripples from one group to the next. The result can optionally be
//   registered.
//
// Parameters
//   WIDTH    operand width, must be a multiple of 4
//   REG_OUT  0 = combinational outputs, 1 = registered outputs (1-cycle latency)
//
// Ports
//   clk  in   1      rising-edge clock (only used when REG_OUT=1)
//   rst  in   1      synchronous active-high reset (only used when REG_OUT=1)
//   x    in   WIDTH  operand A, unsigned
//   y    in   WIDTH  operand B, unsigned
//   a    out  WIDTH  upper half of the sum = {0..0, carry_out}
//   b    out  WIDTH  lower half of the sum = (x + y) mod 2^WIDTH
// ----------------------------------------------------------------------------
module f_adder #(
    parameter int WIDTH   = 12,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] w_g;      // per-bit generate
    logic [WIDTH-1:0] w_p;      // per-bit propagate
    logic [WIDTH-1:0] w_c;      // carry into each bit
    logic [NG-1:0]    w_gg;     // group generate
    logic [NG-1:0]    w_gp;     // group propagate
    logic [NG:0]      w_gc;     // carry into each group; w_gc[NG] is carry out
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Carry into group k, expanded as a flat sum of products over all lower
    // groups: OR_j ( G[j] & P[j+1] & ... & P[k-1] ). Carry into bit 0 is 0,
    // so there is no carry-in term.
    function automatic logic f_lookahead(input logic [NG-1:0] gg,
                                         input logic [NG-1:0] gp,
                                         input int            k);
        logic c;
        logic term;
        c = 1'b0;
        for (int j = 0; j < k; j++) begin
            term = gg[j];
            for (int m = j + 1; m < k; m++) begin
                term = term & gp[m];
            end
            c = c | term;
        end
        return c;
    endfunction

    assign w_g = x & y;
    assign w_p = x ^ y;

    genvar k;
    generate
        // 4-bit CLA groups: internal carries from the group carry-in, plus
        // group G/P for the second level.
        for (k = 0; k < NG; k++) begin : g_cla
            logic [3:0] w_lg;
            logic [3:0] w_lp;
            logic       w_cin;

            assign w_lg  = w_g[4*k +: 4];
            assign w_lp  = w_p[4*k +: 4];
            assign w_cin = w_gc[k];

            assign w_c[4*k]     = w_cin;
            assign w_c[4*k + 1] = w_lg[0] | (w_lp[0] & w_cin);
            assign w_c[4*k + 2] = w_lg[1] | (w_lp[1] & w_lg[0])
                                | (w_lp[1] & w_lp[0] & w_cin);
            assign w_c[4*k + 3] = w_lg[2] | (w_lp[2] & w_lg[1])
                                | (w_lp[2] & w_lp[1] & w_lg[0])
                                | (w_lp[2] & w_lp[1] & w_lp[0] & w_cin);

            assign w_gg[k] = w_lg[3] | (w_lp[3] & w_lg[2])
                           | (w_lp[3] & w_lp[2] & w_lg[1])
                           | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
            assign w_gp[k] = &w_lp;
        end

        // Second-level lookahead unit: every group carry-in (and the final
        // carry out) comes straight from group G/P.
        for (k = 0; k <= NG; k++) begin : g_lookahead
            assign w_gc[k] = f_lookahead(w_gg, w_gp, k);
        end
    endgenerate

    assign w_sum  = w_p ^ w_c;
    assign w_cout = w_gc[NG];

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            // Reset wins over capture; the edge after reset releases takes
            // whatever x, y are present then.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else begin
                    r_a <= {{(WIDTH-1){1'b0}}, w_cout};
                    r_b <= w_sum;
                end
            end

            assign a = r_a;
            assign b = r_b;
        end else begin : g_comb
            // clk and rst play no part in the combinational build.
            logic w_unused;
            assign w_unused = clk ^ rst;

            assign a = {{(WIDTH-1){1'b0}}, w_cout};
            assign b = w_sum;
        end
    endgenerate

endmodule

// File: tb/tb_f_adder.sv
module tb_f_adder;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] a_c, b_c;   // combinational instance
    logic [W-1:0] a_r, b_r;   // registered instance

    int passed;
    int total;

    f_adder #(.WIDTH(W), .REG_OUT(1'b0)) u_comb (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .a   (a_c),
        .b   (b_c)
    );

    f_adder #(.WIDTH(W), .REG_OUT(1'b1)) u_reg (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .a   (a_r),
        .b   (b_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer addition split into halves.
    function automatic logic [W-1:0] ref_hi(input logic [W-1:0] xv, input logic [W-1:0] yv);
        int unsigned s;
        s = int'(xv) + int'(yv);
        return W'(s >> W);
    endfunction

    function automatic logic [W-1:0] ref_lo(input logic [W-1:0] xv, input logic [W-1:0] yv);
        int unsigned s;
        s = int'(xv) + int'(yv);
        return W'(s % (1 << W));
    endfunction

    // Combinational check of one vector against explicit expected values.
    task automatic comb_vec(input string nm, input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input logic [W-1:0] ea, input logic [W-1:0] eb);
        x = xv;
        y = yv;
        #1;
        total++;
        if (a_c !== ea || b_c !== eb)
            $display("FAIL %s: x=%h y=%h got a=%h b=%h expected a=%h b=%h", nm, xv, yv, a_c, b_c, ea, eb);
        else
            passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        x = 12'hABC;
        y = 12'hDEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (a_r !== 12'h000 || b_r !== 12'h000)
            $display("FAIL reset: got a=%h b=%h expected a=000 b=000", a_r, b_r);
        else
            passed++;
    endtask

    task automatic test_basic();
        comb_vec("basic_1_0",       12'h001, 12'h000, 12'h000, 12'h001);
        comb_vec("basic_801_800",   12'h801, 12'h800, 12'h001, 12'h001);
        comb_vec("basic_800_7ff",   12'h800, 12'h7FF, 12'h000, 12'hFFF);
        comb_vec("max_sum",         12'hFFF, 12'hFFF, 12'h001, 12'hFFE);
        comb_vec("exact_2powW",     12'hFFF, 12'h001, 12'h001, 12'h000);
        comb_vec("zero",            12'h000, 12'h000, 12'h000, 12'h000);
    endtask

    task automatic test_sweep();
        int errs;
        errs = 0;
        for (int i = 0; i < 4096; i++) begin
            y = W'(i);
            x = W'((i + 1) % 4096);
            #1;
            total++;
            if (a_c !== ref_hi(x, y) || b_c !== ref_lo(x, y)) begin
                if (errs < 10)
                    $display("FAIL sweep: x=%h y=%h got a=%h b=%h expected a=%h b=%h",
                             x, y, a_c, b_c, ref_hi(x, y), ref_lo(x, y));
                errs++;
            end else begin
                passed++;
            end
        end
        total++;
        if (a_c !== 12'h000 || b_c !== 12'hFFF)
            $display("FAIL sweep_end: got a=%h b=%h expected a=000 b=fff", a_c, b_c);
        else
            passed++;
    endtask

    task automatic test_random_comb();
        logic [W-1:0] xv, yv;
        for (int i = 0; i < 300; i++) begin
            xv = W'($urandom);
            yv = W'($urandom);
            x = xv;
            y = yv;
            #1;
            total++;
            if (a_c !== ref_hi(xv, yv) || b_c !== ref_lo(xv, yv))
                $display("FAIL random_comb: x=%h y=%h got a=%h b=%h expected a=%h b=%h",
                         xv, yv, a_c, b_c, ref_hi(xv, yv), ref_lo(xv, yv));
            else
                passed++;
        end
    endtask

    task automatic test_reg_capture();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        x = 12'hFFF;
        y = 12'h002;
        #1;
        total++;
        if (a_r !== 12'h000 || b_r !== 12'h000)
            $display("FAIL reg_before_edge: got a=%h b=%h expected a=000 b=000", a_r, b_r);
        else
            passed++;
        @(posedge clk);
        #1;
        total++;
        if (a_r !== 12'h001 || b_r !== 12'h001)
            $display("FAIL reg_capture: got a=%h b=%h expected a=001 b=001", a_r, b_r);
        else
            passed++;
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1;
        x = 12'h900;
        y = 12'h900;
        @(posedge clk);
        #1;
        total++;
        if (a_r !== 12'h000 || b_r !== 12'h000)
            $display("FAIL reset_priority: got a=%h b=%h expected a=000 b=000", a_r, b_r);
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (a_r !== 12'h001 || b_r !== 12'h200)
            $display("FAIL after_reset_capture: got a=%h b=%h expected a=001 b=200", a_r, b_r);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] xv, yv, ea, eb;
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            xv = W'($urandom);
            yv = W'($urandom);
            if (i % 17 == 0) begin
                xv = 12'hFFF;
                yv = W'($urandom_range(1, 4095));
            end
            x = xv;
            y = yv;
            qa.push_back(ref_hi(xv, yv));
            qb.push_back(ref_lo(xv, yv));
            @(posedge clk);
            #1;
            ea = qa.pop_front();
            eb = qb.pop_front();
            total++;
            if (a_r !== ea || b_r !== eb)
                $display("FAIL back_to_back: cycle %0d got a=%h b=%h expected a=%h b=%h",
                         i, a_r, b_r, ea, eb);
            else
                passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        x      = '0;
        y      = '0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_basic();
        test_sweep();
        test_random_comb();
        test_reg_capture();
        test_reset_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
